// File: rtl/cmp_pkg.sv
// Purpose: shared constants and helpers for the sequential magnitude comparator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cmp_pkg;

  // FSM encoding. A single bit is enough because there are only two states.
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_COMPARE = 1'b1;

  // Result flag encoding used when the three flags travel together as one bus.
  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_flags_t;

  // Number of DIGIT-wide slices in a WIDTH-bit operand.
  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction

  // Width of the digit down counter. The counter holds values up to
  // NUM_DIGITS-1, so clog2(NUM_DIGITS) bits suffice. A single-digit
  // configuration still needs a 1-bit counter to avoid a zero-width vector.
  function automatic int cnt_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/digit_comparator.sv
// Purpose: combinational unsigned compare of one DIGIT-wide slice.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; outputs follow inputs.
//
// Ports:
//   a, b  in   DIGIT  digit slices to compare (unsigned)
//   lt    out  1      a < b
//   eq    out  1      a == b
//   gt    out  1      a > b
module digit_comparator #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  assign lt = (a <  b);
  assign eq = (a == b);
  assign gt = (a >  b);

endmodule

// File: rtl/seq_mag_comparator.sv
// Purpose: multi-cycle MSB-first magnitude comparator, DIGIT bits per cycle, signed/unsigned.
// Latency: done 1..NUM_DIGITS cycles after the start edge (first differing digit when EARLY_EXIT=1).
// Backpressure: start is ignored while busy; a start in the done cycle is accepted.
//
// Ports:
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   start        in   1      request; accepted only when busy==0
//   signed_mode  in   1      1: operands are two's complement; sampled with start
//   A, B         in   WIDTH  operands; sampled with start
//   busy         out  1      comparison in progress
//   done         out  1      one-cycle completion pulse
//   A_lt_B       out  1      registered result A < B  (held until next completion)
//   A_eq_B       out  1      registered result A == B (held until next completion)
//   A_gt_B       out  1      registered result A > B  (held until next completion)
module seq_mag_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DIGIT      = 2,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             A_lt_B,
  output logic             A_eq_B,
  output logic             A_gt_B
);

  localparam int NUM_DIGITS = num_digits(WIDTH, DIGIT);
  localparam int CW         = cnt_width(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LOAD = CW'(NUM_DIGITS - 1);

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  logic [0:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CW-1:0]    cnt;
  logic             dec_lt;   // sticky decision, only used when EARLY_EXIT=0
  logic             dec_gt;

  // ------------------------------------------------------------------
  // Operand load: flipping the sign bit maps two's complement order onto
  // unsigned order (-2^(W-1) -> 0, 2^(W-1)-1 -> all ones), so the digit
  // datapath only ever needs an unsigned compare.
  // ------------------------------------------------------------------
  logic [WIDTH-1:0] sign_flip;
  logic [WIDTH-1:0] a_load;
  logic [WIDTH-1:0] b_load;

  assign sign_flip = {signed_mode, {(WIDTH-1){1'b0}}};
  assign a_load    = A ^ sign_flip;
  assign b_load    = B ^ sign_flip;

  // ------------------------------------------------------------------
  // Top-digit compare
  // ------------------------------------------------------------------
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic             dig_lt;
  logic             dig_eq;
  logic             dig_gt;

  assign a_dig = a_sh[WIDTH-1 -: DIGIT];
  assign b_dig = b_sh[WIDTH-1 -: DIGIT];

  digit_comparator #(
    .DIGIT (DIGIT)
  ) u_digit_cmp (
    .a  (a_dig),
    .b  (b_dig),
    .lt (dig_lt),
    .eq (dig_eq),
    .gt (dig_gt)
  );

  // ------------------------------------------------------------------
  // Completion and result selection
  // ------------------------------------------------------------------
  logic       in_compare;
  logic       diff_seen;
  logic       dig_diff;
  logic       last_digit;
  logic       early_hit;
  logic       finish;
  cmp_flags_t result;

  assign in_compare = (state == ST_COMPARE);
  assign diff_seen  = dec_lt | dec_gt;
  assign dig_diff   = ~dig_eq;
  assign last_digit = (cnt == '0);
  assign early_hit  = (EARLY_EXIT != 0) && dig_diff;
  assign finish     = in_compare && (early_hit || last_digit);

  // The most significant differing digit decides. If an earlier digit
  // already differed, its sticky decision wins over the current digit;
  // otherwise the current digit decides (this also covers the early-exit
  // case, where diff_seen is never set before finishing).
  always_comb begin
    result = '0;
    if (diff_seen) begin
      result.lt = dec_lt;
      result.gt = dec_gt;
    end else begin
      result.lt = dig_lt;
      result.eq = dig_eq;
      result.gt = dig_gt;
    end
  end

  // ------------------------------------------------------------------
  // FSM, datapath and output registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      cnt    <= '0;
      dec_lt <= 1'b0;
      dec_gt <= 1'b0;
      done   <= 1'b0;
      A_lt_B <= 1'b0;
      A_eq_B <= 1'b0;
      A_gt_B <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Result flags are deliberately left alone here: they hold the
          // previous outcome until this new operation completes.
          if (start) begin
            a_sh   <= a_load;
            b_sh   <= b_load;
            cnt    <= CNT_LOAD;
            dec_lt <= 1'b0;
            dec_gt <= 1'b0;
            state  <= ST_COMPARE;
          end
        end
        ST_COMPARE: begin
          a_sh <= a_sh << DIGIT;
          b_sh <= b_sh << DIGIT;
          cnt  <= cnt - 1'b1;
          // Capture only the first difference; later digits are less
          // significant and must not override it.
          if (dig_diff && !diff_seen) begin
            dec_lt <= dig_lt;
            dec_gt <= dig_gt;
          end
          if (finish) begin
            state  <= ST_IDLE;
            done   <= 1'b1;
            A_lt_B <= result.lt;
            A_eq_B <= result.eq;
            A_gt_B <= result.gt;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // busy is a decode of a registered state bit, so it is glitch-free.
  assign busy = in_compare;

endmodule
